regfile_wb: RTL and testbench
=============================

# regfile_wb

Writeback stage sitting directly upstream of the register file: it merges single-cycle ALU results with results from long-latency units (load/divide) and drives the regfile write port (wr_en, wr_addr, wr_data) from registers. A 2-entry FIFO buffers long-latency results. A per-register scoreboard flags registers with outstanding long-latency writes so decode can stall. A starvation counter guarantees the FIFO drains under continuous ALU traffic.

## Interface
One clock; reset is asynchronous and active-low.
- WIDTH, 32, data width and register count; AW = $clog2(WIDTH)
- STARVE_MAX, 4, consecutive ALU-won cycles with FIFO non-empty before alu_hold asserts (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  AW  ALU destination
- alu_data  in  WIDTH  ALU result
- lng_valid  in  1  long-latency result offered
- lng_ready  out  1  FIFO can accept
- lng_rd  in  AW  long-latency destination
- lng_data  in  WIDTH  long-latency result
- iss_valid  in  1  long-latency op issued this cycle
- iss_rd  in  AW  its destination
- q_rs1, q_rs2, q_rd  in  AW  decode query addresses
- busy  out  1  any non-zero queried register has a pending long-latency write
- alu_hold  out  1  upstream must not present alu_valid this cycle
- wr_en  out  1  to regfile
- wr_addr  out  AW  to regfile
- wr_data  out  WIDTH  to regfile

## Operation
- ALU slot claim: alu_valid && alu_rd != 0. A claim wins the write slot unconditionally. alu_valid with alu_rd == 0 is discarded and leaves the slot free.
- FIFO: 2 entries, circular, 1-bit pointers plus a 2-bit count.
  - Push on lng_valid && lng_ready.
  - Pop when the FIFO is non-empty and there is no ALU claim.
  - Push and pop in the same cycle leave the count unchanged.
  - lng_ready = (count < 2) && rst high. It is computed from registered count; a same-cycle pop does not free space.
- Write register: each edge loads exactly one of the following.
  - ALU claim: wr_en=1, alu_rd, alu_data, src=ALU.
  - Else FIFO pop: wr_en = (head rd != 0), head rd/data, src=LNG. A popped entry with rd 0 is dropped silently.
  - Else: wr_en=0. wr_addr and wr_data hold their previous values.
- Scoreboard pend[WIDTH-1:0]:
  - Set pend[iss_rd] on iss_valid && iss_rd != 0.
  - Clear pend[wr_addr] at the edge where wr_en && src==LNG, i.e. when the data lands in the regfile.
  - Set and clear of the same register in the same cycle: set wins.
  - pend[0] is constant 0.
  - busy = pend[q_rs1] | pend[q_rs2] | pend[q_rd], combinational.
  - Issuing to an already-pending rd is illegal; decode must stall on busy.
- Starvation counter:
  - Increments on cycles with count != 0 and an ALU claim, saturating at STARVE_MAX.
  - Resets to 0 on any pop or when the FIFO is empty.
  - alu_hold is registered: it is 1 in the cycle after the counter reaches STARVE_MAX, for exactly one cycle, and the counter then clears.
  - If alu_valid arrives during alu_hold anyway, the ALU still wins; the bench flags this as a protocol error.
- Reset (any time, including mid-operation): FIFO emptied, pend cleared, counter 0, pending write discarded.
  - Outputs while rst low: wr_en=0, wr_addr=0, wr_data=0, lng_ready=0, alu_hold=0, busy=0.

## Timing
- ALU result in cycle t: wr_en=1 in cycle t+1; regfile updated at the end of t+1.
- Long result accepted at the end of cycle t, with no ALU claims: popped in cycle t+1, wr_en=1 in cycle t+2, busy for that rd drops in cycle t+3.
- Long-latency throughput: one per cycle while the ALU slot is free. lng_ready falls only when count==2.
- Worst-case FIFO head wait under continuous ALU traffic: STARVE_MAX+1 cycles before alu_hold frees a slot.
- busy, lng_ready: combinational from state and query inputs. wr_*, alu_hold: registered.

## Test plan
- Reset, then 3 consecutive ALU writes (rd 5/6/7, data 0x11/0x22/0x33) -> wr_en high cycles 1-3 with matching addr/data.
- ALU writes with alu_rd=0 -> wr_en stays 0.
- iss rd=9; lng result rd=9 data 0xDEAD accepted at cycle t with no ALU traffic -> busy(q_rs1=9) stays 1 through t+2, wr to 9 in cycle t+2, busy=0 in t+3.
- Continuous alu_valid with 3 lng results offered -> lng_ready=0 after 2 accepts; alu_hold pulses after STARVE_MAX=4 blocked cycles; FIFO drains one entry per hold.
- Same-cycle iss_valid rd=4 and long writeback clearing rd 4 -> pend[4] remains 1.
- Assert rst with FIFO full and pend non-zero -> all outputs 0 immediately; after release lng_ready=1 and busy=0 for all queries.

Source files
------------

// File: rtl/regfile_wb.sv
// Writeback stage ahead of the register file: merges ALU results with buffered
// long-latency results, tracks outstanding long writes and prevents FIFO starvation.
module regfile_wb #(
  parameter int  WIDTH      = 32,
  parameter int  STARVE_MAX = 4,
  localparam int AW         = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             lng_valid,
  output logic             lng_ready,
  input  logic [AW-1:0]    lng_rd,
  input  logic [WIDTH-1:0] lng_data,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic [AW-1:0]    q_rs1,
  input  logic [AW-1:0]    q_rs2,
  input  logic [AW-1:0]    q_rd,
  output logic             busy,
  output logic             alu_hold,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LNG = 1'b1} src_e;

  logic [AW-1:0]    fifo_rd   [2];
  logic [WIDTH-1:0] fifo_data [2];
  logic             head, tail;
  logic [1:0]       count, count_next;
  logic [WIDTH-1:0] pend, pend_next;
  logic [CW-1:0]    starve_cnt, starve_cnt_next;
  logic             hold_next;
  src_e             wr_src;

  logic alu_claim, push, pop;

  assign alu_claim = alu_valid && (alu_rd != '0);
  // Ready looks only at the registered count, so a same-cycle pop never frees space.
  assign lng_ready = (count < 2'd2) && rst;
  assign push      = lng_valid && lng_ready;
  assign pop       = (count != 2'd0) && !alu_claim;

  assign busy = pend[q_rs1] | pend[q_rs2] | pend[q_rd];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 2'd1;
    else if (pop && !push)
      count_next = count - 2'd1;
  end

  always_comb begin
    pend_next = pend;
    if (wr_en && wr_src == SRC_LNG)
      pend_next[wr_addr] = 1'b0;
    // A new issue to the register being retired must stay pending, so set comes last.
    if (iss_valid && iss_rd != '0)
      pend_next[iss_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (alu_hold || pop || count == 2'd0)
      starve_cnt_next = '0;
    else if (alu_claim && starve_cnt != CW'(STARVE_MAX))
      starve_cnt_next = starve_cnt + 1'b1;
  end

  // One-cycle pulse; the counter is cleared during the pulse so it cannot re-arm.
  assign hold_next = (starve_cnt == CW'(STARVE_MAX)) && !alu_hold;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail]   <= lng_rd;
      fifo_data[tail] <= lng_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head       <= 1'b0;
      tail       <= 1'b0;
      count      <= 2'd0;
      pend       <= '0;
      starve_cnt <= '0;
      alu_hold   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_src     <= SRC_ALU;
    end else begin
      head       <= head ^ pop;
      tail       <= tail ^ push;
      count      <= count_next;
      pend       <= pend_next;
      starve_cnt <= starve_cnt_next;
      alu_hold   <= hold_next;
      if (alu_claim) begin
        wr_en   <= 1'b1;
        wr_addr <= alu_rd;
        wr_data <= alu_data;
        wr_src  <= SRC_ALU;
      end else if (pop) begin
        wr_en   <= (fifo_rd[head] != '0);
        wr_addr <= fifo_rd[head];
        wr_data <= fifo_data[head];
        wr_src  <= SRC_LNG;
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: vector table for single-cycle behaviour plus
// hand-written starvation and mid-operation reset sequences.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lng_valid = 1'b0;
  logic        lng_ready;
  logic [4:0]  lng_rd = '0;
  logic [31:0] lng_data = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic [4:0]  q_rs1 = '0, q_rs2 = '0, q_rd = '0;
  logic        busy, alu_hold, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb #(.WIDTH(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lng_valid(lng_valid), .lng_ready(lng_ready), .lng_rd(lng_rd), .lng_data(lng_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
    .busy(busy), .alu_hold(alu_hold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] adata;
    logic        lv;  logic [4:0] lrd; logic [31:0] ldata;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  q1, q2, qd;
    logic        e_wr_en, chk_wr; logic [4:0] e_addr; logic [31:0] e_data;
    logic        e_busy, e_ready, e_hold;
  } vec_t;

  function automatic vec_t mk(input int av, input int ard, input int ad,
                              input int lv, input int lrd, input int ld,
                              input int iv, input int ird,
                              input int q1, input int q2, input int qd,
                              input int ewe, input int chk, input int ea, input int ed,
                              input int eb, input int er, input int eh);
    vec_t r;
    r.av = 1'(av);  r.ard = 5'(ard);  r.adata = 32'(ad);
    r.lv = 1'(lv);  r.lrd = 5'(lrd);  r.ldata = 32'(ld);
    r.iv = 1'(iv);  r.ird = 5'(ird);
    r.q1 = 5'(q1);  r.q2 = 5'(q2);    r.qd = 5'(qd);
    r.e_wr_en = 1'(ewe); r.chk_wr = 1'(chk); r.e_addr = 5'(ea); r.e_data = 32'(ed);
    r.e_busy = 1'(eb); r.e_ready = 1'(er); r.e_hold = 1'(eh);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lng_valid = 1'b0; lng_rd = '0; lng_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;
  endtask

  vec_t vecs [24];

  logic [4:0]  lrds  [3] = '{5'd20, 5'd21, 5'd22};
  logic [31:0] ldats [3] = '{32'hA0, 32'hA1, 32'hA2};

  initial begin
    //         alu          lng              iss   q1 q2 qd  wr_en chk addr data   busy rdy hold
    vecs[0]  = mk(1,5,'h11,   0,0,0,          0,0,  0,0,0,  0,0,0,0,             0,1,0);
    vecs[1]  = mk(1,6,'h22,   0,0,0,          0,0,  0,0,0,  1,1,5,'h11,          0,1,0);
    vecs[2]  = mk(1,7,'h33,   0,0,0,          0,0,  0,0,0,  1,1,6,'h22,          0,1,0);
    vecs[3]  = mk(1,0,'h44,   0,0,0,          0,0,  0,0,0,  1,1,7,'h33,          0,1,0);
    vecs[4]  = mk(1,0,'h55,   0,0,0,          0,0,  0,0,0,  0,1,7,'h33,          0,1,0);
    vecs[5]  = mk(0,0,0,      0,0,0,          1,9,  9,0,0,  0,1,7,'h33,          0,1,0);
    vecs[6]  = mk(0,0,0,      1,9,'hDEAD,     0,0,  9,0,0,  0,0,0,0,             1,1,0);
    vecs[7]  = mk(0,0,0,      0,0,0,          0,0,  9,0,0,  0,0,0,0,             1,1,0);
    vecs[8]  = mk(0,0,0,      0,0,0,          0,0,  9,0,0,  1,1,9,'hDEAD,        1,1,0);
    vecs[9]  = mk(0,0,0,      0,0,0,          0,0,  9,0,0,  0,1,9,'hDEAD,        0,1,0);
    vecs[10] = mk(0,0,0,      0,0,0,          1,4,  0,4,0,  0,0,0,0,             0,1,0);
    vecs[11] = mk(0,0,0,      1,4,'hBEEF,     0,0,  0,4,0,  0,0,0,0,             1,1,0);
    vecs[12] = mk(0,0,0,      0,0,0,          0,0,  0,4,0,  0,0,0,0,             1,1,0);
    vecs[13] = mk(0,0,0,      0,0,0,          1,4,  0,4,0,  1,1,4,'hBEEF,        1,1,0);
    vecs[14] = mk(0,0,0,      0,0,0,          0,0,  0,4,0,  0,0,0,0,             1,1,0);
    vecs[15] = mk(0,0,0,      0,0,0,          0,0,  0,0,4,  0,0,0,0,             1,1,0);
    vecs[16] = mk(0,0,0,      0,0,0,          1,0,  0,0,0,  0,0,0,0,             0,1,0);
    vecs[17] = mk(0,0,0,      1,0,'h77,       0,0,  0,0,0,  0,0,0,0,             0,1,0);
    vecs[18] = mk(0,0,0,      0,0,0,          0,0,  0,0,4,  0,0,0,0,             1,1,0);
    vecs[19] = mk(0,0,0,      0,0,0,          0,0,  0,0,0,  0,0,0,0,             0,1,0);
    vecs[20] = mk(1,8,'h888,  1,3,'h333,      0,0,  0,0,0,  0,0,0,0,             0,1,0);
    vecs[21] = mk(0,0,0,      0,0,0,          0,0,  0,0,0,  1,1,8,'h888,         0,1,0);
    vecs[22] = mk(0,0,0,      0,0,0,          0,0,  0,0,0,  1,1,3,'h333,         0,1,0);
    vecs[23] = mk(0,0,0,      0,0,0,          0,0,  0,0,0,  0,1,3,'h333,         0,1,0);

    // Reset state.
    #2 rst = 1'b0;
    @(negedge clk); #1;
    check("reset wr_en", 32'(wr_en), 0);
    check("reset wr_addr", 32'(wr_addr), 0);
    check("reset wr_data", wr_data, 0);
    check("reset lng_ready", 32'(lng_ready), 0);
    check("reset alu_hold", 32'(alu_hold), 0);
    check("reset busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adata;
      lng_valid = vecs[i].lv; lng_rd = vecs[i].lrd; lng_data = vecs[i].ldata;
      iss_valid = vecs[i].iv; iss_rd = vecs[i].ird;
      q_rs1 = vecs[i].q1; q_rs2 = vecs[i].q2; q_rd = vecs[i].qd;
      #1;
      $display("vec %0d: wr_en=%0b wr_addr=%0d wr_data=%0h busy=%0b lng_ready=%0b alu_hold=%0b",
               i, wr_en, wr_addr, wr_data, busy, lng_ready, alu_hold);
      check($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(vecs[i].e_wr_en));
      if (vecs[i].chk_wr) begin
        check($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].e_addr));
        check($sformatf("vec%0d wr_data", i), wr_data, vecs[i].e_data);
      end
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d lng_ready", i), 32'(lng_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d alu_hold", i), 32'(alu_hold), 32'(vecs[i].e_hold));
    end

    // Starvation: continuous ALU traffic, three long results offered.
    begin
      int          li;
      logic        prev_claim, exp_hold, exp_ready;
      logic [4:0]  prev_rd;
      logic [31:0] prev_data;
      li = 0; prev_claim = 1'b0; prev_rd = '0; prev_data = '0;
      for (int c = 0; c < 21; c++) begin
        @(negedge clk);
        idle_inputs();
        exp_hold  = (c == 6 || c == 12 || c == 18);
        exp_ready = !((c >= 2 && c <= 6) || (c >= 8 && c <= 12));
        alu_valid = (c < 20) && !exp_hold;
        alu_rd    = 5'(10 + c % 5);
        alu_data  = 32'h1000 + 32'(c);
        lng_valid = (li < 3);
        lng_rd    = (li < 3) ? lrds[li] : 5'd0;
        lng_data  = (li < 3) ? ldats[li] : 32'd0;
        #1;
        $display("starve cyc %0d: wr_en=%0b wr_addr=%0d wr_data=%0h lng_ready=%0b alu_hold=%0b",
                 c, wr_en, wr_addr, wr_data, lng_ready, alu_hold);
        check($sformatf("starve%0d alu_hold", c), 32'(alu_hold), 32'(exp_hold));
        check($sformatf("starve%0d lng_ready", c), 32'(lng_ready), 32'(exp_ready));
        check($sformatf("starve%0d protocol", c), 32'(alu_valid && alu_hold), 0);
        if (c == 7 || c == 13 || c == 19) begin
          check($sformatf("starve%0d wr_en", c), 32'(wr_en), 1);
          check($sformatf("starve%0d wr_addr", c), 32'(wr_addr), 32'(lrds[(c - 7) / 6]));
          check($sformatf("starve%0d wr_data", c), wr_data, ldats[(c - 7) / 6]);
        end else if (prev_claim) begin
          check($sformatf("starve%0d wr_en", c), 32'(wr_en), 1);
          check($sformatf("starve%0d wr_addr", c), 32'(wr_addr), 32'(prev_rd));
          check($sformatf("starve%0d wr_data", c), wr_data, prev_data);
        end else begin
          check($sformatf("starve%0d wr_en", c), 32'(wr_en), 0);
        end
        prev_claim = alu_valid; prev_rd = alu_rd; prev_data = alu_data;
        if (lng_valid && lng_ready) li++;
      end
      check("starve accepted", 32'(li), 3);
    end

    // Reset with the FIFO full and a register pending.
    @(negedge clk);
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA;
    lng_valid = 1'b1; lng_rd = 5'd12; lng_data = 32'hC12;
    iss_valid = 1'b1; iss_rd = 5'd12;
    #1;
    check("prerst0 lng_ready", 32'(lng_ready), 1);
    @(negedge clk);
    alu_rd = 5'd2; alu_data = 32'hB;
    lng_rd = 5'd13; lng_data = 32'hC13;
    iss_valid = 1'b0; q_rs1 = 5'd12;
    #1;
    check("prerst1 busy", 32'(busy), 1);
    check("prerst1 wr_addr", 32'(wr_addr), 1);
    @(negedge clk);
    alu_rd = 5'd3; alu_data = 32'hC;
    lng_rd = 5'd14; lng_data = 32'hC14;
    #1;
    check("prerst2 lng_ready", 32'(lng_ready), 0);
    check("prerst2 busy", 32'(busy), 1);
    check("prerst2 wr_en", 32'(wr_en), 1);
    check("prerst2 wr_data", wr_data, 32'hB);
    rst = 1'b0;
    #1;
    $display("mid reset: wr_en=%0b wr_addr=%0d wr_data=%0h lng_ready=%0b alu_hold=%0b busy=%0b",
             wr_en, wr_addr, wr_data, lng_ready, alu_hold, busy);
    check("midrst wr_en", 32'(wr_en), 0);
    check("midrst wr_addr", 32'(wr_addr), 0);
    check("midrst wr_data", wr_data, 0);
    check("midrst lng_ready", 32'(lng_ready), 0);
    check("midrst alu_hold", 32'(alu_hold), 0);
    check("midrst busy", 32'(busy), 0);
    @(negedge clk); #1;
    check("inrst wr_en", 32'(wr_en), 0);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    q_rs1 = 5'd12; q_rs2 = 5'd13; q_rd = 5'd14;
    #1;
    check("postrst lng_ready", 32'(lng_ready), 1);
    check("postrst busy", 32'(busy), 0);
    check("postrst wr_en", 32'(wr_en), 0);
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hF0;
    #1;
    check("postrst drained wr_en", 32'(wr_en), 0);
    @(negedge clk);
    idle_inputs();
    #1;
    $display("post reset write: wr_en=%0b wr_addr=%0d wr_data=%0h", wr_en, wr_addr, wr_data);
    check("postrst alu wr_en", 32'(wr_en), 1);
    check("postrst alu wr_addr", 32'(wr_addr), 1);
    check("postrst alu wr_data", wr_data, 32'hF0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
